cpu_trace_buffer: RTL and testbench

Parametrised trace-capture block for the CPU. It records a configurable number of CPU observation channels, such as PC, IR, ALU output and status, into a circular buffer on every qualified sample. Capture freezes a programmable number of samples after a trigger. The captured window is then streamed out oldest-first over a valid/ready port. It sits beside the `cpu` core as an on-chip replacement for waveform dumping, so ROM runs can be inspected in hardware.

---
 rtl/cpu_trace_buffer.sv | 184 ++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Circular trace buffer for CPU observation channels: captures qualified samples,
// freezes a programmable number of samples after a trigger, then streams the window oldest-first.
module cpu_trace_buffer #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 64,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*DATA_W-1:0] ch_data,
    input  logic                       sample_en,
    input  logic                       trig_in,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [AW-1:0]              post_len,
    output logic [CHANNELS*DATA_W-1:0] rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       rd_last,
    output logic [1:0]                 state,
    output logic [AW:0]                count,
    output logic [AW-1:0]              trig_pos
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);
    localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO_C = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE_C  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO_C  = (AW+1)'(2);
    localparam logic [AW:0]   FULL_C     = (AW+1)'(DEPTH);

    logic [CHANNELS*DATA_W-1:0] mem [DEPTH];

    state_t        state_r, state_n;
    logic [AW-1:0] wr_ptr_r, wr_ptr_n;
    logic [AW-1:0] rd_ptr_r, rd_ptr_n;
    logic [AW:0]   count_r, count_n;
    logic [AW-1:0] trig_pos_r, trig_pos_n;
    logic [AW-1:0] post_cnt_r, post_cnt_n;
    logic [AW-1:0] post_len_r, post_len_n;
    logic          rd_valid_r, rd_valid_n;
    logic          rd_last_r, rd_last_n;
    logic          wr_en_s;
    logic          done_s;

    // Next-state and datapath control; abort overrides every other request.
    always_comb begin
        state_n    = state_r;
        wr_ptr_n   = wr_ptr_r;
        rd_ptr_n   = rd_ptr_r;
        count_n    = count_r;
        trig_pos_n = trig_pos_r;
        post_cnt_n = post_cnt_r;
        post_len_n = post_len_r;
        rd_valid_n = rd_valid_r;
        rd_last_n  = rd_last_r;
        wr_en_s    = 1'b0;
        done_s     = 1'b0;

        if (abort) begin
            state_n    = IDLE;
            count_n    = CNT_ZERO_C;
            rd_valid_n = 1'b0;
            rd_last_n  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arm) begin
                        state_n  = ARMED;
                        wr_ptr_n = PTR_ZERO_C;
                        count_n  = CNT_ZERO_C;
                    end else begin
                        state_n = IDLE;
                    end
                end
                ARMED, POST: begin
                    if (sample_en) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_n = wr_ptr_r + PTR_ONE_C;
                        count_n  = (count_r == FULL_C) ? FULL_C : count_r + CNT_ONE_C;
                        if (state_r == ARMED) begin
                            // post_len is AW bits wide, so it never exceeds DEPTH-1 and the trigger sample survives.
                            if (trig_in) begin
                                post_len_n = post_len;
                                post_cnt_n = post_len;
                                if (post_len == PTR_ZERO_C) begin
                                    done_s = 1'b1;
                                end else begin
                                    state_n = POST;
                                end
                            end else begin
                                post_cnt_n = post_cnt_r;
                            end
                        end else begin
                            post_cnt_n = post_cnt_r - PTR_ONE_C;
                            done_s     = (post_cnt_r == PTR_ONE_C);
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end

                    // Readout window starts at the oldest surviving entry, using post-write pointer and count.
                    if (done_s) begin
                        state_n    = DONE;
                        rd_ptr_n   = wr_ptr_n - count_n[AW-1:0];
                        trig_pos_n = AW'(count_n - CNT_ONE_C - {1'b0, post_len_n});
                        rd_valid_n = 1'b1;
                        rd_last_n  = (count_n == CNT_ONE_C);
                    end else begin
                        rd_valid_n = 1'b0;
                    end
                end
                DONE: begin
                    if (rd_valid_r && rd_ready) begin
                        rd_ptr_n = rd_ptr_r + PTR_ONE_C;
                        count_n  = count_r - CNT_ONE_C;
                        if (count_r == CNT_ONE_C) begin
                            state_n    = IDLE;
                            rd_valid_n = 1'b0;
                            rd_last_n  = 1'b0;
                        end else begin
                            rd_last_n = (count_r == CNT_TWO_C);
                        end
                    end else begin
                        rd_valid_n = rd_valid_r;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    rd_valid_n = 1'b0;
                    rd_last_n  = 1'b0;
                end
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= PTR_ZERO_C;
            rd_ptr_r   <= PTR_ZERO_C;
            count_r    <= CNT_ZERO_C;
            trig_pos_r <= PTR_ZERO_C;
            post_cnt_r <= PTR_ZERO_C;
            post_len_r <= PTR_ZERO_C;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            state_r    <= state_n;
            wr_ptr_r   <= wr_ptr_n;
            rd_ptr_r   <= rd_ptr_n;
            count_r    <= count_n;
            trig_pos_r <= trig_pos_n;
            post_cnt_r <= post_cnt_n;
            post_len_r <= post_len_n;
            rd_valid_r <= rd_valid_n;
            rd_last_r  <= rd_last_n;
        end
    end

    // Trace memory write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= ch_data;
        end
    end

    assign rd_data  = mem[rd_ptr_r];
    assign rd_valid = rd_valid_r;
    assign rd_last  = rd_last_r;
    assign state    = state_r;
    assign count    = count_r;
    assign trig_pos = trig_pos_r;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios with randomized channel data
// checked against a sample-window reference model held in a queue.
module tb_cpu_trace_buffer;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int W        = CHANNELS * DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  ch_data;
    logic          sample_en;
    logic          trig_in;
    logic          arm;
    logic          abort;
    logic [AW-1:0] post_len;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic [1:0]    state;
    logic [AW:0]   count;
    logic [AW-1:0] trig_pos;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] q[$];

    cpu_trace_buffer #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .sample_en(sample_en), .trig_in(trig_in),
        .arm(arm), .abort(abort), .post_len(post_len), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_last(rd_last), .state(state), .count(count), .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arm, feed n_pre plain samples, a trigger sample with post length plen, then
    // post-trigger samples plus n_extra samples that must be ignored once frozen.
    task automatic capture(input int n_pre, input int plen, input int n_extra);
        int eff;
        int total;
        int exp_state;
        eff   = (plen > DEPTH - 1) ? DEPTH - 1 : plen;
        total = n_pre + 1 + eff;
        q.delete();
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("armed", 64'(state), 64'd1);
        chk("armed_count", 64'(count), 64'd0);
        for (int i = 1; i <= total + n_extra; i++) begin
            if (i <= n_pre && $urandom_range(0, 1) == 1) begin
                sample_en = 1'b0;
                trig_in   = 1'b1;
                ch_data   = W'($urandom);
                step();
                chk("idle_trig_ignored", 64'(state), 64'd1);
            end
            ch_data   = {16'($urandom_range(0, 65535)), 16'(i)};
            sample_en = 1'b1;
            if (i == n_pre + 1) trig_in = 1'b1;
            else if (i > n_pre + 1) trig_in = 1'($urandom_range(0, 1));
            else trig_in = 1'b0;
            post_len = AW'(plen);
            step();
            if (i <= total) begin
                q.push_back(ch_data);
                if (q.size() > DEPTH) void'(q.pop_front());
            end
            exp_state = (i <= n_pre) ? 1 : ((i < total) ? 2 : 3);
            chk("state_cap", 64'(state), 64'(exp_state));
        end
        sample_en = 1'b0;
        trig_in   = 1'b0;
        chk("done_count", 64'(count), 64'(q.size()));
        chk("trig_pos", 64'(trig_pos), 64'(q.size() - 1 - eff));
        chk("trig_entry", 64'(q[q.size() - 1 - eff][15:0]), 64'(n_pre + 1));
    endtask

    // Drain the window; stall selects the 1,0,0,1,0,0 ready pattern.
    task automatic readout(input bit stall);
        int idx = 0;
        int cyc = 0;
        while (idx < q.size() && cyc < 200) begin
            rd_ready = stall ? (cyc % 3 == 0) : 1'b1;
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("rd_data", 64'(rd_data), 64'(q[idx]));
            chk("rd_last", 64'(rd_last), 64'(idx == q.size() - 1));
            step();
            if (rd_ready) idx++;
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_accepts", 64'(idx), 64'(q.size()));
        chk("rd_end_state", 64'(state), 64'd0);
        chk("rd_end_valid", 64'(rd_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ch_data = '0; sample_en = 1'b0; trig_in = 1'b0; arm = 1'b0;
        abort = 1'b0; post_len = '0; rd_ready = 1'b0;
        #2;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_last", 64'(rd_last), 64'd0);
        chk("rst_trig_pos", 64'(trig_pos), 64'd0);
        #10 rst = 1'b1;
        step();
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        chk("idle_ignores_sample", 64'(count), 64'd0);

        // Wrap + trigger, then short capture.
        capture(12, 2, 0);
        chk("wrap_trig_pos", 64'(trig_pos), 64'd5);
        chk("wrap_oldest", 64'(q[0][15:0]), 64'd8);
        readout(1'b0);
        capture(3, 0, 0);
        chk("short_count", 64'(count), 64'd4);
        chk("short_trig_pos", 64'(trig_pos), 64'd3);
        readout(1'b0);

        // Clamp at the maximum post length, read out under backpressure.
        capture(8, 7, 13);
        chk("clamp_trig_pos", 64'(trig_pos), 64'd0);
        chk("clamp_first", 64'(q[0][15:0]), 64'd9);
        readout(1'b1);

        // Abort in POST, then arm and abort together in IDLE.
        arm = 1'b1; step(); arm = 1'b0;
        ch_data = 32'h0000_0001; sample_en = 1'b1; step();
        ch_data = 32'h0000_0002; trig_in = 1'b1; post_len = 3'd5; step();
        trig_in = 1'b0; ch_data = 32'h0000_0003; step();
        chk("abort_pre_state", 64'(state), 64'd2);
        abort = 1'b1; arm = 1'b1; step();
        chk("abort_post_state", 64'(state), 64'd0);
        chk("abort_post_count", 64'(count), 64'd0);
        step();
        chk("abort_arm_state", 64'(state), 64'd0);
        chk("abort_arm_count", 64'(count), 64'd0);
        abort = 1'b0; arm = 1'b0; sample_en = 1'b0;
        step();
        chk("abort_idle_hold", 64'(state), 64'd0);

        // Asynchronous reset mid-readout.
        capture(5, 1, 0);
        rd_ready = 1'b1; step(); step(); rd_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 64'(rd_valid), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        #2 rst = 1'b1;
        step();
        capture(2, 1, 0);
        readout(1'b0);

        // Randomized windows.
        for (int k = 0; k < 4; k++) begin
            capture($urandom_range(0, 12), $urandom_range(0, 7), $urandom_range(0, 3));
            readout(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
